// File: rtl/servo_pkg.sv
// Shared constants, parser state encoding and helpers for the servo command scheduler.
package servo_pkg;

  localparam int          POS_W             = 8;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    GET_CH    = 2'd1,
    GET_POS   = 2'd2
  } parse_state_e;

  // Channel index width, never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Move cur toward tgt by at most step, landing exactly on tgt when close enough.
  function automatic logic [POS_W-1:0] slew_step(input logic [POS_W-1:0] cur,
                                                 input logic [POS_W-1:0] tgt,
                                                 input logic [POS_W-1:0] step);
    if (tgt > cur) begin
      return ((tgt - cur) > step) ? (cur + step) : tgt;
    end else if (cur > tgt) begin
      return ((cur - tgt) > step) ? (cur - step) : tgt;
    end
    return cur;
  endfunction

endpackage

// File: rtl/servo_frame_parser.sv
// Decodes SYNC/channel/position byte frames into single-cycle pending-position writes,
// with an inter-byte timeout while a frame is open.
module servo_frame_parser
  import servo_pkg::*;
#(
  parameter int         NUM_CH      = 4,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         CH_W        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  output logic             wr_en_o,
  output logic [CH_W-1:0]  wr_ch_o,
  output logic [POS_W-1:0] wr_pos_o,
  output logic             cmd_err_o,
  output logic             busy_o
);

  localparam int         CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] NUM_CH_B = 8'(NUM_CH);

  parse_state_e     state_q;
  logic [CH_W-1:0]  ch_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             busy_q;

  // The position write is taken on the same edge that accepts the final byte.
  assign wr_en_o   = rx_valid_i && (state_q == GET_POS);
  assign wr_ch_o   = ch_q;
  assign wr_pos_o  = rx_data_i;
  assign cmd_err_o = err_q;
  assign busy_o    = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_SYNC;
      ch_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (rx_valid_i) begin
        cnt_q <= '0;
        case (state_q)
          WAIT_SYNC: begin
            if (rx_data_i == SYNC_BYTE) begin
              state_q <= GET_CH;
              busy_q  <= 1'b1;
            end
          end
          GET_CH: begin
            // A repeated SYNC simply restarts the frame.
            if (rx_data_i == SYNC_BYTE) begin
              state_q <= GET_CH;
            end else if (rx_data_i < NUM_CH_B) begin
              ch_q    <= rx_data_i[CH_W-1:0];
              state_q <= GET_POS;
            end else begin
              err_q   <= 1'b1;
              state_q <= WAIT_SYNC;
              busy_q  <= 1'b0;
            end
          end
          GET_POS: begin
            state_q <= WAIT_SYNC;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= WAIT_SYNC;
            busy_q  <= 1'b0;
          end
        endcase
      end else if (state_q != WAIT_SYNC) begin
        if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_q   <= 1'b1;
          state_q <= WAIT_SYNC;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/servo_cmd_scheduler.sv
// Servo command scheduler: buffers per-channel positions from UART frames and commits them
// on frame boundaries. Define SERVO_SLEW_LIMIT_EN to rate-limit each commit to MAX_STEP.
module servo_cmd_scheduler
  import servo_pkg::*;
#(
  parameter int               NUM_CH      = 4,
  parameter logic [7:0]       SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int               TIMEOUT_CYC = 50000,
  parameter logic [POS_W-1:0] DEFAULT_POS = 8'd128,
  parameter int               MAX_STEP    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    cycle_start,
  output logic [NUM_CH*POS_W-1:0] pos_out,
  output logic                    pos_update,
  output logic                    cmd_err,
  output logic                    busy
);

  localparam int CH_W = ch_width(NUM_CH);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("NUM_CH must be in 1..8");
  end
  if (MAX_STEP < 1 || MAX_STEP > 255) begin : g_bad_max_step
    $error("MAX_STEP must be in 1..255");
  end

  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [POS_W-1:0] wr_pos;

  servo_frame_parser #(
    .NUM_CH      (NUM_CH),
    .SYNC_BYTE   (SYNC_BYTE),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CH_W        (CH_W)
  ) u_parser (
    .clk        (clk),
    .rst        (rst),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .wr_en_o    (wr_en),
    .wr_ch_o    (wr_ch),
    .wr_pos_o   (wr_pos),
    .cmd_err_o  (cmd_err),
    .busy_o     (busy)
  );

  logic cs_q;
  logic cs_prev_q;
  logic commit;
  logic pos_update_q;
  logic pos_update_d;
  logic [NUM_CH-1:0] dirty_v;

  // One commit per rising edge of the frame-boundary level, however long it stays high.
  assign commit = cs_q && !cs_prev_q;

`ifdef SERVO_SLEW_LIMIT_EN
  localparam logic [POS_W-1:0] STEP = POS_W'(MAX_STEP);
  logic [NUM_CH-1:0] changed_v;
  assign pos_update_d = |changed_v;
`else
  assign pos_update_d = commit && (|dirty_v);
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pend_q;
    logic             dirty_q;
    logic [POS_W-1:0] pos_d;
    logic             hit;

    assign hit = wr_en && (wr_ch == CH_W'(gi));
`ifdef SERVO_SLEW_LIMIT_EN
    assign pos_d         = slew_step(pos_q, pend_q, STEP);
    assign changed_v[gi] = commit && dirty_q && (pos_d != pos_q);
`else
    assign pos_d = pend_q;
`endif

    // A write landing on the commit edge wins the dirty bit, so it goes out next frame.
    always_ff @(posedge clk) begin
      if (rst) begin
        pos_q   <= DEFAULT_POS;
        pend_q  <= DEFAULT_POS;
        dirty_q <= 1'b0;
      end else begin
        if (commit && dirty_q) begin
          pos_q <= pos_d;
          if (pos_d == pend_q) begin
            dirty_q <= 1'b0;
          end
        end
        if (hit) begin
          pend_q  <= wr_pos;
          dirty_q <= 1'b1;
        end
      end
    end

    assign dirty_v[gi]                 = dirty_q;
    assign pos_out[gi*POS_W +: POS_W]  = pos_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q         <= 1'b0;
      cs_prev_q    <= 1'b0;
      pos_update_q <= 1'b0;
    end else begin
      cs_q         <= cycle_start;
      cs_prev_q    <= cs_q;
      pos_update_q <= pos_update_d;
    end
  end

  assign pos_update = pos_update_q;

endmodule

// File: tb/tb_servo_cmd_scheduler.sv
// Self-checking bench for servo_cmd_scheduler: directed scenarios plus randomized frames
// compared against a frame-level reference model.
module tb_servo_cmd_scheduler;

  localparam int NUM_CH   = 4;
  localparam int TIMEOUT  = 50000;
  localparam int MAX_STEP = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  cycle_start;
  logic [NUM_CH*8-1:0]   pos_out;
  logic                  pos_update;
  logic                  cmd_err;
  logic                  busy;

  servo_cmd_scheduler #(
    .NUM_CH      (NUM_CH),
    .SYNC_BYTE   (8'hFF),
    .TIMEOUT_CYC (TIMEOUT),
    .DEFAULT_POS (8'd128),
    .MAX_STEP    (MAX_STEP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .cycle_start (cycle_start),
    .pos_out     (pos_out),
    .pos_update  (pos_update),
    .cmd_err     (cmd_err),
    .busy        (busy)
  );

  always #10 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int upd_cnt    = 0;
  int err_cnt    = 0;

  always @(negedge clk) begin
    if (pos_update) upd_cnt++;
    if (cmd_err) err_cnt++;
  end

  // Reference model: what each channel should show, what is waiting, and how many
  // update/error pulses the DUT should have produced so far.
  int m_pos[NUM_CH];
  int m_pend[NUM_CH];
  bit m_dirty[NUM_CH];
  int m_phase;   // 0: idle, 1: expecting channel, 2: expecting position
  int m_ch;
  int exp_err = 0;
  int exp_upd = 0;

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_pos[i] = 128; m_pend[i] = 128; m_dirty[i] = 1'b0;
    end
    m_phase = 0;
    m_ch    = 0;
  endfunction

  function automatic void model_byte(input int b);
    if (m_phase == 0) begin
      if (b == 255) m_phase = 1;
    end else if (m_phase == 1) begin
      if (b == 255) m_phase = 1;
      else if (b < NUM_CH) begin m_ch = b; m_phase = 2; end
      else begin exp_err++; m_phase = 0; end
    end else begin
      m_pend[m_ch] = b; m_dirty[m_ch] = 1'b1; m_phase = 0;
    end
  endfunction

  function automatic void model_commit();
    bit any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_dirty[i]) begin
        int nxt;
`ifdef SERVO_SLEW_LIMIT_EN
        int diff = m_pend[i] - m_pos[i];
        if (diff > MAX_STEP) diff = MAX_STEP;
        if (diff < -MAX_STEP) diff = -MAX_STEP;
        nxt = m_pos[i] + diff;
        if (nxt != m_pos[i]) any = 1'b1;
`else
        nxt = m_pend[i];
        any = 1'b1;
`endif
        m_pos[i] = nxt;
        if (m_pos[i] == m_pend[i]) m_dirty[i] = 1'b0;
      end
    end
    if (any) exp_upd++;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    model_byte(int'(b));
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic pulse_commit(input int hold);
    cycle_start = 1'b1;
    tick();
    tick();
    model_commit();
    repeat ((hold > 2) ? hold - 2 : 0) tick();
    cycle_start = 1'b0;
    tick();
  endtask

  task automatic apply_reset();
    rst = 1'b1; rx_valid = 1'b0; cycle_start = 1'b0; rx_data = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      vectors++;
      if (pos_out[i*8 +: 8] !== 8'h80) begin
        miscompares++;
        $display("FAIL reset_pos ch%0d: got %h want 80", i, pos_out[i*8 +: 8]);
      end
    end
    vectors++;
    if ({pos_update, cmd_err, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got upd/err/busy=%b want 000", {pos_update, cmd_err, busy});
    end
    // Reset in the middle of a frame drops it without error or commit.
    send_byte(8'hFF, 0);
    send_byte(8'h01, 0);
    rst = 1'b1; tick(); rst = 1'b0; model_reset(); tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midframe_busy: got %b want 0", busy);
    end
    send_byte(8'h55, 1);
    pulse_commit(4);
    vectors++;
    if (pos_out[15:8] !== 8'h80 || upd_cnt !== exp_upd || err_cnt !== exp_err) begin
      miscompares++;
      $display("FAIL reset_midframe: ch1=%h upd=%0d/%0d err=%0d/%0d want ch1=80",
               pos_out[15:8], upd_cnt, exp_upd, err_cnt, exp_err);
    end
    $display("test_reset done: vectors=%0d", vectors);
  endtask

  task automatic test_commit_latency();
    send_byte(8'hFF, 1);
    send_byte(8'h02, 2);
    send_byte(8'h40, 3);
    cycle_start = 1'b1;
    tick();
    vectors++;
    if (pos_out[23:16] !== 8'h80) begin
      miscompares++;
      $display("FAIL early_commit: ch2 got %h want 80 one clk after rise", pos_out[23:16]);
    end
    tick();
    model_commit();
    vectors++;
    if (pos_out[23:16] !== 8'h40 || pos_update !== 1'b1) begin
      miscompares++;
      $display("FAIL commit_latency: ch2=%h upd=%b want 40/1", pos_out[23:16], pos_update);
    end
    repeat (198) tick();
    cycle_start = 1'b0;
    repeat (2) tick();
    vectors++;
    if (upd_cnt !== exp_upd) begin
      miscompares++;
      $display("FAIL long_level_updates: got %0d want %0d", upd_cnt, exp_upd);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      vectors++;
      if (int'(pos_out[i*8 +: 8]) !== m_pos[i]) begin
        miscompares++;
        $display("FAIL commit_ch%0d: got %h want %h", i, pos_out[i*8 +: 8], m_pos[i]);
      end
    end
    $display("test_commit_latency done: ch2=%h", pos_out[23:16]);
  endtask

  task automatic test_bad_channel();
    send_byte(8'hFF, 0);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_midframe: got %b want 1", busy);
    end
    send_byte(8'h05, 0);
    vectors++;
    if (cmd_err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_channel: err=%b busy=%b want 1/0", cmd_err, busy);
    end
    tick();
    vectors++;
    if (cmd_err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_width: got %b want 0 one clk later", cmd_err);
    end
    send_byte(8'h10, 1);
    pulse_commit(3);
    vectors++;
    if (upd_cnt !== exp_upd || err_cnt !== exp_err) begin
      miscompares++;
      $display("FAIL bad_channel_counts: upd=%0d/%0d err=%0d/%0d", upd_cnt, exp_upd, err_cnt, exp_err);
    end
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 1);
    send_byte(8'h01, 0);
    send_byte(8'hFF, 1);
    pulse_commit(5);
    vectors++;
    if (pos_out[15:8] !== 8'hFF || int'(pos_out[15:8]) !== m_pos[1]) begin
      miscompares++;
      $display("FAIL resync_ff_pos: ch1 got %h want ff", pos_out[15:8]);
    end
    $display("test_bad_channel done: err_cnt=%0d", err_cnt);
  endtask

  task automatic test_timeout();
    int err_at = -1;
    int err_before = err_cnt;
    send_byte(8'hFF, 0);
    send_byte(8'h00, 0);
    for (int n = 1; n <= TIMEOUT + 20; n++) begin
      tick();
      if (cmd_err === 1'b1 && err_at < 0) err_at = n;
    end
    exp_err++;
    m_phase = 0;
    vectors++;
    if (err_at !== TIMEOUT) begin
      miscompares++;
      $display("FAIL timeout_cycle: err at %0d idle clks, want %0d", err_at, TIMEOUT);
    end
    vectors++;
    if (err_cnt - err_before !== 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_once: pulses=%0d busy=%b want 1/0", err_cnt - err_before, busy);
    end
    send_byte(8'h33, 1);
    pulse_commit(3);
    vectors++;
    if (int'(pos_out[7:0]) !== m_pos[0] || pos_out[7:0] !== 8'h80) begin
      miscompares++;
      $display("FAIL timeout_ch0: got %h want 80", pos_out[7:0]);
    end
    $display("test_timeout done: err_at=%0d", err_at);
  endtask

  task automatic test_simultaneous();
    send_byte(8'hFF, 0);
    send_byte(8'h03, 0);
    send_byte(8'h90, 1);
    send_byte(8'hFF, 0);
    send_byte(8'h03, 1);
    cycle_start = 1'b1;
    tick();
    rx_data  = 8'h20;
    rx_valid = 1'b1;
    model_commit();
    model_byte(32'h20);
    tick();
    rx_valid = 1'b0;
    vectors++;
    if (int'(pos_out[31:24]) !== m_pos[3]) begin
      miscompares++;
      $display("FAIL simul_old: ch3 got %h want %h", pos_out[31:24], m_pos[3]);
    end
`ifndef SERVO_SLEW_LIMIT_EN
    vectors++;
    if (pos_out[31:24] !== 8'h90) begin
      miscompares++;
      $display("FAIL simul_old_literal: ch3 got %h want 90", pos_out[31:24]);
    end
`endif
    repeat (3) tick();
    cycle_start = 1'b0;
    tick();
    pulse_commit(3);
    vectors++;
    if (int'(pos_out[31:24]) !== m_pos[3] || upd_cnt !== exp_upd) begin
      miscompares++;
      $display("FAIL simul_next: ch3 got %h want %h upd=%0d/%0d",
               pos_out[31:24], m_pos[3], upd_cnt, exp_upd);
    end
    $display("test_simultaneous done: ch3=%h", pos_out[31:24]);
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      int kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        send_byte(8'hFF, $urandom_range(0, 3));
        send_byte(8'($urandom_range(0, NUM_CH - 1)), $urandom_range(0, 3));
        send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 3));
      end else if (kind == 6) begin
        send_byte(8'hFF, $urandom_range(0, 2));
        send_byte(8'($urandom_range(NUM_CH, 254)), $urandom_range(0, 2));
      end else if (kind == 7) begin
        send_byte(8'($urandom_range(0, 254)), $urandom_range(0, 2));
      end else if (kind == 8) begin
        send_byte(8'hFF, 0);
        send_byte(8'hFF, 1);
        send_byte(8'($urandom_range(0, NUM_CH - 1)), 0);
        send_byte(8'($urandom_range(0, 255)), 1);
      end
      if ($urandom_range(0, 2) == 0 || it == 59) begin
        pulse_commit($urandom_range(2, 20));
        for (int i = 0; i < NUM_CH; i++) begin
          vectors++;
          if (int'(pos_out[i*8 +: 8]) !== m_pos[i]) begin
            miscompares++;
            $display("FAIL rand_pos it%0d ch%0d: got %h want %h", it, i, pos_out[i*8 +: 8], m_pos[i]);
          end
        end
        vectors++;
        if (upd_cnt !== exp_upd || err_cnt !== exp_err) begin
          miscompares++;
          $display("FAIL rand_counts it%0d: upd=%0d/%0d err=%0d/%0d", it, upd_cnt, exp_upd, err_cnt, exp_err);
        end
      end
    end
    $display("test_random done: upd=%0d err=%0d", upd_cnt, err_cnt);
  endtask

`ifdef SERVO_SLEW_LIMIT_EN
  task automatic test_slew();
    int steps[5];
    int upd_before;
    steps[0] = 'h88; steps[1] = 'h90; steps[2] = 'h98; steps[3] = 'hA0; steps[4] = 'hA0;
    apply_reset();
    send_byte(8'hFF, 0);
    send_byte(8'h00, 0);
    send_byte(8'hA0, 1);
    for (int f = 0; f < 5; f++) begin
      upd_before = upd_cnt;
      pulse_commit(4);
      vectors++;
      if (int'(pos_out[7:0]) !== steps[f] || int'(pos_out[7:0]) !== m_pos[0]) begin
        miscompares++;
        $display("FAIL slew_frame%0d: ch0 got %h want %h", f, pos_out[7:0], steps[f]);
      end
      vectors++;
      if (upd_cnt - upd_before !== ((f < 4) ? 1 : 0)) begin
        miscompares++;
        $display("FAIL slew_update%0d: pulses %0d want %0d", f, upd_cnt - upd_before, (f < 4) ? 1 : 0);
      end
    end
    $display("test_slew done: ch0=%h", pos_out[7:0]);
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_commit_latency();
    test_bad_channel();
    test_timeout();
    test_simultaneous();
    test_random();
`ifdef SERVO_SLEW_LIMIT_EN
    test_slew();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/servo_cmd_scheduler.md
Name: servo_cmd_scheduler

Overview:
Sits between the UART receiver and a bank of NUM_CH servo pulse generators.
- Parses 3-byte command frames (SYNC, channel, position) into per-channel pending positions.
- Commits pending positions to the pulse generators only at a frame boundary, so a pulse never changes width mid-pulse.
- Flags malformed or stalled frames.

Parameters:
NUM_CH, 4, number of servo channels (1..8)
SYNC_BYTE, 8'hFF, frame start marker
TIMEOUT_CYC, 50000, max clk cycles between bytes inside a frame (1 ms at 50 MHz)
DEFAULT_POS, 8'd128, reset position for every channel (mid-travel, 1.5 ms pulse)
MAX_STEP, 8, per-frame position step limit (used only with SERVO_SLEW_LIMIT_EN)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-high
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe, rx_data valid
cycle_start  in  1  frame-boundary level from the pulse generator; may stay high for many clk cycles
pos_out  out  NUM_CH*8  committed positions; channel i is at [8i+7:8i]
pos_update  out  1  one-cycle pulse when any channel is committed
cmd_err  out  1  one-cycle pulse on a bad channel or a timeout
busy  out  1  high while the parser is mid-frame (not in WAIT_SYNC)

Behaviour:
- Clocking: single clock domain; reset is synchronous and active-high, sampled on posedge clk.
- Reset values:
  - pos_out = DEFAULT_POS on all channels; pending = DEFAULT_POS; dirty = 0.
  - pos_update = 0, cmd_err = 0, busy = 0.
  - Parser state = WAIT_SYNC; timeout counter = 0.
- Reset mid-frame discards the partial frame; no commit, no cmd_err.
- Parser FSM, advanced only on rx_valid except for timeout:
  - WAIT_SYNC: byte == SYNC_BYTE -> GET_CH; any other byte is ignored silently.
  - GET_CH:
    - byte == SYNC_BYTE -> stay in GET_CH (resync, no error).
    - byte < NUM_CH -> latch channel, go to GET_POS.
    - otherwise -> cmd_err pulse, go to WAIT_SYNC.
  - GET_POS: any byte, 0xFF included, is the position. Write pending[ch] = byte, set dirty[ch] = 1, go to WAIT_SYNC.
  - Timeout counter runs only in GET_CH and GET_POS, and is cleared on every rx_valid. On reaching TIMEOUT_CYC-1 it raises cmd_err and returns to WAIT_SYNC. cmd_err is registered, one cycle after the detecting edge.
  - A second write to the same channel before commit overwrites pending; last write wins.
- Commit:
  - cycle_start is registered once and rising-edge detected, giving exactly one commit per frame however long the level stays high.
  - On the commit cycle, every channel with dirty = 1 copies pending into pos_out and clears dirty.
  - pos_update pulses for one cycle, registered on the cycle after the edge detect, only if at least one channel was dirty.
  - Latency: cycle_start rise -> pos_out valid = 2 clk.
- Simultaneous commit and GET_POS write:
  - If the write targets the committing channel, the commit uses the old pending value. The new value lands in pending with dirty = 1 and goes out at the next frame.
  - Writes to other channels are unaffected.
- Channel count: the channel index is $clog2(NUM_CH) bits wide, with a minimum of 1; the comparison against NUM_CH is done on the full 8-bit byte.

Optional Feature:
SERVO_SLEW_LIMIT_EN.
- Defined: at commit, pos_out[i] moves toward pending[i] by at most MAX_STEP, saturating at the target with no overshoot. dirty[i] clears only when pos_out[i] == pending[i]. pos_update pulses on every frame in which any output changed.
- Undefined: direct copy as described in Behaviour; MAX_STEP is unused.

Decomposition:
- Package servo_pkg:
  - SYNC_BYTE_DEFAULT.
  - Parser state encoding: WAIT_SYNC = 2'd0, GET_CH = 2'd1, GET_POS = 2'd2.
  - Position width constant POS_W = 8.
- Sub-module servo_frame_parser holds the FSM plus the timeout counter.
  - Outputs: wr_en, wr_ch, wr_pos, cmd_err, busy.
  - The top level holds the pending/dirty/pos_out registers and the commit logic.

Test Plan:
1. Reset, then idle -> all pos_out = 0x80; pos_update, cmd_err and busy all 0.
2. Frame FF,02,40, then a cycle_start pulse lasting 200 clk -> pos_out ch2 = 0x40 exactly 2 clk after the rise; one pos_update; other channels stay 0x80.
3. Frame FF,05,10 (NUM_CH = 4) -> cmd_err for 1 cycle, no pending change. Then FF,FF,01,FF -> ch1 = 0xFF after the next commit.
4. FF,00, then 50000 idle cycles -> cmd_err once and busy drops. A following byte 0x33 is ignored, and ch0 is unchanged after commit.
5. Last byte 0x20 to ch3 on the same clk as the commit edge, with ch3 pending 0x90 -> this frame ch3 = 0x90; next frame ch3 = 0x20.
6. With SERVO_SLEW_LIMIT_EN, ch0 0x80 -> 0xA0, MAX_STEP = 8 -> successive frames give 0x88, 0x90, 0x98, 0xA0, then no further pos_update.
